// File: rtl/storage_port_arbiter.sv
// Round-robin arbiter sharing the single Matrix_Storage read/write port among N_REQ requesters.
// One owner at a time; reads are tagged through a READ_LAT pipe and returned to the issuer.
module storage_port_arbiter #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned HOLD_LIMIT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_release,
    output logic [N_REQ-1:0]         o_grant,
    input  logic [N_REQ-1:0]         i_rd_en,
    input  logic [N_REQ*ADDR_W-1:0]  i_rd_addr,
    input  logic [N_REQ-1:0]         i_we,
    input  logic [N_REQ*ADDR_W-1:0]  i_waddr,
    input  logic [N_REQ*DATA_W-1:0]  i_wdata,
    output logic [ADDR_W-1:0]        o_mem_raddr,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    output logic                     o_mem_we,
    output logic [ADDR_W-1:0]        o_mem_waddr,
    output logic [DATA_W-1:0]        o_mem_wdata,
    output logic [DATA_W-1:0]        o_rdata,
    output logic [N_REQ-1:0]         o_rvalid,
    output logic [1:0]               o_owner,
    output logic                     o_busy,
    output logic                     o_timeout
);

    localparam int unsigned HC_W = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT) : 1;
    localparam int unsigned DC_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [1:0]       LAST_IDX = 2'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

    state_t             state, state_nx;
    logic [1:0]         ptr;
    logic [1:0]         win_idx;
    logic               win_any;
    logic               own_req, own_rel, own_we, own_rd;
    logic [ADDR_W-1:0]  own_waddr, own_raddr;
    logic [DATA_W-1:0]  own_wdata;
    logic               hold_hit, leave, forced;
    logic               fwd_we, fwd_rd;
    logic [HC_W-1:0]    hold_cnt;
    logic [DC_W-1:0]    drain_cnt;
    logic [READ_LAT-1:0] tag_v;
    logic [1:0]         tag_o [READ_LAT];
    logic [N_REQ-1:0]   rv_nx;

    always_comb begin
        own_req   = 1'b0;
        own_rel   = 1'b0;
        own_we    = 1'b0;
        own_rd    = 1'b0;
        own_waddr = '0;
        own_raddr = '0;
        own_wdata = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (o_owner == 2'(k)) begin
                own_req   = i_req[k];
                own_rel   = i_release[k];
                own_we    = i_we[k];
                own_rd    = i_rd_en[k];
                own_waddr = i_waddr[k*ADDR_W +: ADDR_W];
                own_raddr = i_rd_addr[k*ADDR_W +: ADDR_W];
                own_wdata = i_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Lowest requester overall, then overridden by the lowest one at/after ptr: circular priority.
    always_comb begin
        win_any = |i_req;
        win_idx = '0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            if (i_req[k-1]) win_idx = 2'(k - 1);
        end
        for (int unsigned k = N_REQ; k > 0; k--) begin
            if (i_req[k-1] && (2'(k - 1) >= ptr)) win_idx = 2'(k - 1);
        end
    end

    always_comb begin
        state_nx = state;
        leave    = 1'b0;
        forced   = 1'b0;
        hold_hit = (HOLD_LIMIT != 0) && (hold_cnt == HC_W'(HOLD_LIMIT - 1));
        case (state)
            S_IDLE: begin
                if (win_any) state_nx = S_GRANT;
            end
            S_GRANT: begin
                leave  = own_rel | ~own_req | hold_hit;
                forced = hold_hit & own_req & ~own_rel;
                if (leave) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt == DC_W'(READ_LAT - 1)) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign fwd_we = (state == S_GRANT) & own_we;
    assign fwd_rd = (state == S_GRANT) & own_rd;
    assign o_busy = (state != S_IDLE);

    always_comb begin
        rv_nx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rv_nx[k] = tag_v[READ_LAT-1] && (tag_o[READ_LAT-1] == 2'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_grant     <= '0;
            o_owner     <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
            drain_cnt   <= '0;
            o_mem_we    <= 1'b0;
            o_mem_waddr <= '0;
            o_mem_wdata <= '0;
            o_mem_raddr <= '0;
            o_rdata     <= '0;
            o_rvalid    <= '0;
            o_timeout   <= 1'b0;
            tag_v       <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) tag_o[i] <= '0;
        end else begin
            o_mem_we  <= fwd_we;
            o_timeout <= forced;
            if (fwd_we) begin
                o_mem_waddr <= own_waddr;
                o_mem_wdata <= own_wdata;
            end
            if (fwd_rd) o_mem_raddr <= own_raddr;

            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        o_grant  <= ONE_HOT0 << win_idx;
                        o_owner  <= win_idx;
                        hold_cnt <= '0;
                    end
                end
                S_GRANT: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (leave) begin
                        o_grant   <= '0;
                        drain_cnt <= '0;
                        ptr       <= (o_owner == LAST_IDX) ? 2'd0 : o_owner + 2'd1;
                    end
                end
                S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
                default: ;
            endcase

            // Tag enters with the address register edge and exits READ_LAT edges later.
            tag_v[0] <= fwd_rd;
            tag_o[0] <= o_owner;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_o[i] <= tag_o[i-1];
            end
            o_rvalid <= rv_nx;
            if (tag_v[READ_LAT-1]) o_rdata <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_storage_port_arbiter.sv
// Bench for storage_port_arbiter: directed scenarios plus randomized traffic against
// a transaction-level reference model (owner/gap/pointer plus a queue of pending reads).
module tb_storage_port_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 2;
    localparam int unsigned HL = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      i_req, i_release, i_rd_en, i_we;
    logic [N*AW-1:0]   i_rd_addr, i_waddr;
    logic [N*DW-1:0]   i_wdata;
    logic [DW-1:0]     i_mem_rdata;
    logic [N-1:0]      o_grant, o_rvalid;
    logic [AW-1:0]     o_mem_raddr, o_mem_waddr;
    logic              o_mem_we, o_busy, o_timeout;
    logic [DW-1:0]     o_mem_wdata, o_rdata;
    logic [1:0]        o_owner;

    storage_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .HOLD_LIMIT(HL)) dut (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_release(i_release), .o_grant(o_grant),
        .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .i_we(i_we), .i_waddr(i_waddr),
        .i_wdata(i_wdata), .o_mem_raddr(o_mem_raddr), .i_mem_rdata(i_mem_rdata),
        .o_mem_we(o_mem_we), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
        .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_owner(o_owner), .o_busy(o_busy),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    // Storage with one internal register stage: address edge + 2 = capture edge.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem_q;
    always @(posedge clk) mem_q <= mem[o_mem_raddr];
    assign i_mem_rdata = mem_q;

    typedef struct { int due; int own; logic [DW-1:0] data; } rd_t;
    rd_t rq[$];

    int            m_owner, m_gap, m_ptr, m_hold, cycle;
    logic [N-1:0]  exp_grant, exp_rvalid;
    logic [1:0]    exp_owner;
    logic          exp_busy, exp_we, exp_timeout, rd_issued;
    logic [AW-1:0] exp_waddr, exp_raddr;
    logic [DW-1:0] exp_wdata, exp_rdata;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic model_reset();
        m_owner = -1; m_gap = 0; m_ptr = 0; m_hold = 0;
        rq.delete();
        exp_grant = '0; exp_rvalid = '0; exp_owner = '0; exp_busy = 1'b0;
        exp_we = 1'b0; exp_timeout = 1'b0; rd_issued = 1'b0;
        exp_waddr = '0; exp_raddr = '0; exp_wdata = '0; exp_rdata = '0;
    endtask

    task automatic model_step();
        int o;
        rd_t q;
        bit normal;
        cycle++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        exp_we = 1'b0; exp_timeout = 1'b0; exp_rvalid = '0; rd_issued = 1'b0;
        if (rq.size() > 0 && rq[0].due == cycle) begin
            q = rq.pop_front();
            exp_rvalid[q.own] = 1'b1;
            exp_rdata = q.data;
        end
        if (m_owner >= 0) begin
            o = m_owner;
            m_hold++;
            if (i_we[o]) begin
                exp_we = 1'b1;
                exp_waddr = i_waddr[o*AW +: AW];
                exp_wdata = i_wdata[o*DW +: DW];
            end
            if (i_rd_en[o]) begin
                rd_issued = 1'b1;
                exp_raddr = i_rd_addr[o*AW +: AW];
                rq.push_back('{due: cycle + RL, own: o, data: mem[i_rd_addr[o*AW +: AW]]});
            end
            normal = i_release[o] || !i_req[o];
            if (normal || m_hold == HL) begin
                exp_timeout = !normal;
                m_owner = -1;
                m_gap = RL;
                m_ptr = (o + 1) % N;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && i_req[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                    m_hold = 0;
                    exp_owner = 2'(m_owner);
                end
            end
        end
        exp_grant = '0;
        if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
        exp_busy = (m_owner >= 0) || (m_gap > 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        i_req = '0; i_release = '0; i_rd_en = '0; i_we = '0;
        i_rd_addr = '0; i_waddr = '0; i_wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", o_grant); end
        n_tests++; if (o_rvalid !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 000", o_rvalid); end
        n_tests++; if ({o_busy, o_mem_we, o_timeout, o_owner} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: busy/we/timeout/owner got %b want 00000", {o_busy, o_mem_we, o_timeout, o_owner});
        end
        n_tests++; if ({o_mem_raddr, o_mem_waddr, o_mem_wdata, o_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {o_mem_raddr, o_mem_waddr, o_mem_wdata, o_rdata});
        end
    endtask

    task automatic test_single_write();
        do_reset();
        i_req = 3'b001;
        tick();
        n_tests++; if (o_grant !== 3'b001) begin n_fail++; $display("FAIL t1_grant: got %b want 001", o_grant); end
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy: got %b want 1", o_busy); end
        i_we = 3'b001; i_waddr[0 +: AW] = 8'h10; i_wdata[0 +: DW] = 32'hDEADBEEF;
        tick();
        n_tests++; if (o_mem_we !== 1'b1) begin n_fail++; $display("FAIL t1_we: got %b want 1", o_mem_we); end
        n_tests++; if (o_mem_waddr !== 8'h10) begin n_fail++; $display("FAIL t1_waddr: got %h want 10", o_mem_waddr); end
        n_tests++; if (o_mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t1_wdata: got %h want deadbeef", o_mem_wdata); end
        i_we = '0;
        tick();
        n_tests++; if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL t1_we_off: got %b want 0", o_mem_we); end
    endtask

    task automatic test_round_robin();
        do_reset();
        i_req = 3'b101;
        tick();
        n_tests++; if (o_grant !== 3'b001) begin n_fail++; $display("FAIL t2_first: got %b want 001", o_grant); end
        i_release = 3'b001;
        tick();
        i_release = '0; i_req = 3'b100;
        for (int i = 0; i < RL + 1; i++) begin
            n_tests++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL t2_gap[%0d]: got %b want 000", i, o_grant); end
            tick();
        end
        n_tests++; if (o_grant !== 3'b100) begin n_fail++; $display("FAIL t2_second: got %b want 100", o_grant); end
        n_tests++; if (o_owner !== 2'd2) begin n_fail++; $display("FAIL t2_owner: got %0d want 2", o_owner); end
        i_release = 3'b100; i_req = 3'b111;
        tick();
        i_release = '0;
        for (int i = 0; i < RL + 1; i++) tick();
        n_tests++; if (o_grant !== 3'b001) begin n_fail++; $display("FAIL t2_wrap: got %b want 001", o_grant); end
    endtask

    task automatic test_read_return();
        do_reset();
        i_req = 3'b010;
        tick();
        i_rd_en = 3'b010; i_rd_addr[AW +: AW] = 8'h05; i_release = 3'b010;
        tick();
        n_tests++; if (o_mem_raddr !== 8'h05) begin n_fail++; $display("FAIL t3_raddr: got %h want 05", o_mem_raddr); end
        n_tests++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL t3_released: got %b want 000", o_grant); end
        clear_inputs();
        for (int i = 1; i < RL; i++) begin
            tick();
            n_tests++; if (o_rvalid !== 3'b000) begin n_fail++; $display("FAIL t3_early: got %b want 000", o_rvalid); end
        end
        tick();
        n_tests++; if (o_rvalid !== 3'b010) begin n_fail++; $display("FAIL t3_rvalid: got %b want 010", o_rvalid); end
        n_tests++; if (o_rdata !== 32'h00001234) begin n_fail++; $display("FAIL t3_rdata: got %h want 00001234", o_rdata); end
        tick();
        n_tests++; if (o_rvalid !== 3'b000) begin n_fail++; $display("FAIL t3_pulse: got %b want 000", o_rvalid); end
        n_tests++; if (o_rdata !== 32'h00001234) begin n_fail++; $display("FAIL t3_hold: got %h want 00001234", o_rdata); end
    endtask

    task automatic test_non_owner();
        do_reset();
        i_req = 3'b010;
        tick();
        i_we = 3'b001; i_rd_en = 3'b001; i_waddr[0 +: AW] = 8'h22; i_rd_addr[0 +: AW] = 8'h33;
        i_release = 3'b001;
        tick();
        n_tests++; if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL t4_we: got %b want 0", o_mem_we); end
        n_tests++; if (o_grant !== 3'b010) begin n_fail++; $display("FAIL t4_grant: got %b want 010", o_grant); end
        i_we = '0; i_rd_en = '0; i_release = '0;
        for (int i = 0; i < RL + 1; i++) begin
            tick();
            n_tests++; if (o_rvalid !== 3'b000) begin n_fail++; $display("FAIL t4_rvalid[%0d]: got %b want 000", i, o_rvalid); end
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        i_req = 3'b011;
        tick();
        for (int i = 1; i < HL; i++) begin
            tick();
            if (o_timeout === 1'b1) pulses++;
            n_tests++; if (o_grant !== 3'b001) begin n_fail++; $display("FAIL t5_hold[%0d]: got %b want 001", i, o_grant); end
        end
        tick();
        if (o_timeout === 1'b1) pulses++;
        n_tests++; if (o_grant !== 3'b000) begin n_fail++; $display("FAIL t5_drop: got %b want 000", o_grant); end
        n_tests++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL t5_pulse: got %b want 1", o_timeout); end
        for (int i = 0; i < RL + 1; i++) begin
            tick();
            if (o_timeout === 1'b1) pulses++;
        end
        n_tests++; if (o_grant !== 3'b010) begin n_fail++; $display("FAIL t5_next: got %b want 010", o_grant); end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL t5_count: got %0d pulses want 1", pulses); end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_req = 3'b001;
        tick();
        i_rd_en = 3'b001; i_rd_addr[0 +: AW] = 8'h07;
        tick();
        i_rd_en = '0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({o_grant, o_rvalid, o_owner, o_busy, o_mem_we, o_timeout} !== '0) begin
            n_fail++; $display("FAIL t6_ctrl: got %b want 0", {o_grant, o_rvalid, o_owner, o_busy, o_mem_we, o_timeout});
        end
        n_tests++; if ({o_mem_raddr, o_mem_waddr, o_mem_wdata, o_rdata} !== '0) begin
            n_fail++; $display("FAIL t6_data: got %h want 0", {o_mem_raddr, o_mem_waddr, o_mem_wdata, o_rdata});
        end
        i_req = '0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < RL + 3; i++) begin
            tick();
            n_tests++; if (o_rvalid !== 3'b000) begin n_fail++; $display("FAIL t6_rvalid[%0d]: got %b want 000", i, o_rvalid); end
        end
    endtask

    task automatic test_random();
        int b;
        do_reset();
        i_req = 3'($urandom_range(0, 7));
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, N - 1);
                i_req[b] = ~i_req[b];
            end
            i_release = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            i_we      = 3'($urandom);
            i_rd_en   = 3'($urandom);
            i_waddr   = 24'($urandom);
            i_rd_addr = 24'($urandom);
            i_wdata   = {$urandom, $urandom, $urandom};
            tick();
            n_tests++; if (o_grant !== exp_grant) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b want %b", c, o_grant, exp_grant); end
            n_tests++; if (o_owner !== exp_owner) begin n_fail++; $display("FAIL rnd_owner c%0d: got %0d want %0d", c, o_owner, exp_owner); end
            n_tests++; if (o_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, o_busy, exp_busy); end
            n_tests++; if (o_mem_we !== exp_we) begin n_fail++; $display("FAIL rnd_we c%0d: got %b want %b", c, o_mem_we, exp_we); end
            n_tests++; if (o_timeout !== exp_timeout) begin n_fail++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, o_timeout, exp_timeout); end
            n_tests++; if (o_rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, o_rvalid, exp_rvalid); end
            n_tests++; if (o_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, o_rdata, exp_rdata); end
            if (exp_we) begin
                n_tests++; if ({o_mem_waddr, o_mem_wdata} !== {exp_waddr, exp_wdata}) begin
                    n_fail++; $display("FAIL rnd_wr c%0d: got %h/%h want %h/%h", c, o_mem_waddr, o_mem_wdata, exp_waddr, exp_wdata);
                end
            end
            if (rd_issued) begin
                n_tests++; if (o_mem_raddr !== exp_raddr) begin n_fail++; $display("FAIL rnd_raddr c%0d: got %h want %h", c, o_mem_raddr, exp_raddr); end
            end
        end
        clear_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[5] = 32'h00001234;
        cycle = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_return();
        test_non_owner();
        test_timeout();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
